// File: rtl/gyro_var_pkg.sv
// Shared CTRL register layout, SEQ width and address-map helpers for the gyro variable bank.
package gyro_var_pkg;

    localparam int unsigned CTRL_LIVE_BIT = 0;
    localparam int unsigned CTRL_ERR_BIT  = 1;
    localparam int unsigned SEQ_LSB       = 16;
    localparam int unsigned SEQ_W         = 16;

    typedef enum logic [1:0] {
        RegionRw,
        RegionRo,
        RegionCtrl,
        RegionNone
    } region_e;

    // CTRL sits directly after the RW block and the RO block.
    function automatic int unsigned ctrl_offset(input int unsigned n_rw, input int unsigned n_ro);
        return n_rw + n_ro;
    endfunction

endpackage

// File: rtl/gyro_var_snapshot.sv
// Shadow array, 16-bit snapshot sequence counter and delayed snapshot-taken pulse.
module gyro_var_snapshot
    import gyro_var_pkg::*;
#(
    parameter int unsigned N_RO = 60,
    parameter int unsigned DW   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               snap,
    input  logic [N_RO*DW-1:0] live,
    output logic [N_RO*DW-1:0] shadow,
    output logic [SEQ_W-1:0]   seq,
    output logic               latch_trigger
);

    logic [N_RO*DW-1:0] shadow_q;
    logic [SEQ_W-1:0]   seq_q;
    logic               pending_q;
    logic               latch_q;

    // The pulse trails capture by one edge; reset drops any pending pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            seq_q     <= '0;
            pending_q <= 1'b0;
            latch_q   <= 1'b0;
        end else begin
            pending_q <= snap;
            latch_q   <= pending_q;
            if (snap) begin
                shadow_q <= live;
                seq_q    <= seq_q + 1'b1;
            end
        end
    end

    assign shadow        = shadow_q;
    assign seq           = seq_q;
    assign latch_trigger = latch_q;

endmodule

// File: rtl/gyro_var_bank.sv
// Avalon-MM bank of CPU-writable registers and snapshotted read-only channels with a CTRL word.
// Define GYRO_VAR_BANK_BYTEEN_EN to honour byteenable on writes to RW registers and CTRL.
module gyro_var_bank
    import gyro_var_pkg::*;
#(
    parameter int unsigned N_RW     = 60,
    parameter int unsigned N_RO     = 60,
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 8,
    parameter int unsigned TRIG_IDX = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [AW-1:0]      address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic signed [DW-1:0] writedata,
    input  logic [DW/8-1:0]    byteenable,
    output logic signed [DW-1:0] readdata,
    output logic               readdatavalid,
    input  logic               i_snap_req,
    input  logic [N_RO*DW-1:0] i_var,
    output logic [N_RW*DW-1:0] o_reg,
    output logic [N_RW-1:0]    o_wr_stb,
    output logic               o_latch_trigger
);

    localparam int unsigned CTRL_ADDR = ctrl_offset(N_RW, N_RO);
    localparam int unsigned TRIG_ADDR = N_RW + TRIG_IDX;

    logic [31:0]      addr_ext;
    logic             wr;
    logic             rd;
    logic             snap;
    region_e          region;
    logic [DW-1:0]    wmask;
    logic             lane_any;
    logic [N_RW-1:0]  wr_hit;
    logic [DW-1:0]    reg_q [N_RW];
    logic [N_RW-1:0]  wr_stb_q;
    logic             live_q;
    logic             err_q;
    logic [DW-1:0]    rdata_q;
    logic             rdv_q;
    logic [DW-1:0]    rd_value;
    logic [31:0]      ctrl_word;
    logic [N_RO*DW-1:0] shadow;
    logic [SEQ_W-1:0] seq;

    assign addr_ext = 32'(address);
    assign wr       = chipselect & ~write_n;
    assign rd       = chipselect & write_n;
    assign snap     = (rd && addr_ext == TRIG_ADDR) || i_snap_req;

    always_comb begin
        if (addr_ext < N_RW)            region = RegionRw;
        else if (addr_ext < CTRL_ADDR)  region = RegionRo;
        else if (addr_ext == CTRL_ADDR) region = RegionCtrl;
        else                            region = RegionNone;
    end

`ifdef GYRO_VAR_BANK_BYTEEN_EN
    always_comb begin
        wmask = '1;
        for (int b = 0; b < DW / 8; b++) begin
            wmask[b*8 +: 8] = {8{byteenable[b]}};
        end
    end
    assign lane_any = |byteenable;
`else
    logic unused_byteenable;
    assign unused_byteenable = ^byteenable;
    assign wmask    = '1;
    assign lane_any = 1'b1;
`endif

    always_comb begin
        for (int i = 0; i < N_RW; i++) begin
            wr_hit[i] = wr && lane_any && (addr_ext == i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_RW; i++) reg_q[i] <= '0;
            wr_stb_q <= '0;
            live_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_stb_q <= wr_hit;
            for (int i = 0; i < N_RW; i++) begin
                if (wr_hit[i]) reg_q[i] <= (reg_q[i] & ~wmask) | (writedata & wmask);
            end
            if (wr && region == RegionCtrl && wmask[CTRL_LIVE_BIT]) begin
                live_q <= writedata[CTRL_LIVE_BIT];
            end
            // A bad write and an ERR clear cannot share a cycle, so order is free.
            if (wr && (region == RegionRo || region == RegionNone)) begin
                err_q <= 1'b1;
            end else if (wr && region == RegionCtrl && wmask[CTRL_ERR_BIT] &&
                         writedata[CTRL_ERR_BIT]) begin
                err_q <= 1'b0;
            end
        end
    end

    always_comb begin
        ctrl_word                      = '0;
        ctrl_word[CTRL_LIVE_BIT]       = live_q;
        ctrl_word[CTRL_ERR_BIT]        = err_q;
        ctrl_word[SEQ_LSB +: SEQ_W]    = seq;
        rd_value                       = '0;
        case (region)
            RegionRw: begin
                for (int i = 0; i < N_RW; i++) begin
                    if (addr_ext == i) rd_value = reg_q[i];
                end
            end
            RegionRo: begin
                // The trigger channel returns the value being captured this edge.
                for (int k = 0; k < N_RO; k++) begin
                    if (addr_ext == N_RW + k) begin
                        if (k == TRIG_IDX || live_q) rd_value = i_var[k*DW +: DW];
                        else                         rd_value = shadow[k*DW +: DW];
                    end
                end
            end
            RegionCtrl: rd_value = ctrl_word[DW-1:0];
            default:    rd_value = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            rdv_q   <= 1'b0;
        end else begin
            rdv_q <= rd;
            if (rd) rdata_q <= rd_value;
        end
    end

    gyro_var_snapshot #(
        .N_RO (N_RO),
        .DW   (DW)
    ) u_snapshot (
        .clk           (clk),
        .rst_n         (rst_n),
        .snap          (snap),
        .live          (i_var),
        .shadow        (shadow),
        .seq           (seq),
        .latch_trigger (o_latch_trigger)
    );

    for (genvar g = 0; g < N_RW; g++) begin : g_oreg
        assign o_reg[g*DW +: DW] = reg_q[g];
    end

    assign o_wr_stb      = wr_stb_q;
    assign readdata      = rdata_q;
    assign readdatavalid = rdv_q;

endmodule

// File: tb/tb_gyro_var_bank.sv
// Directed self-checking bench for gyro_var_bank at default parameters.
module tb_gyro_var_bank;

    localparam int unsigned N_RW     = 60;
    localparam int unsigned N_RO     = 60;
    localparam int unsigned DW       = 32;
    localparam int unsigned AW       = 8;
    localparam int unsigned TRIG_IDX = 11;
    localparam int unsigned CTRL     = N_RW + N_RO;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [AW-1:0]       address = '0;
    logic                chipselect = 1'b0;
    logic                write_n = 1'b1;
    logic signed [DW-1:0] writedata = '0;
    logic [DW/8-1:0]     byteenable = '1;
    logic signed [DW-1:0] readdata;
    logic                readdatavalid;
    logic                i_snap_req = 1'b0;
    logic [N_RO*DW-1:0]  i_var = '0;
    logic [N_RW*DW-1:0]  o_reg;
    logic [N_RW-1:0]     o_wr_stb;
    logic                o_latch_trigger;

    int tests = 0;
    int fails = 0;

    gyro_var_bank #(
        .N_RW     (N_RW),
        .N_RO     (N_RO),
        .DW       (DW),
        .AW       (AW),
        .TRIG_IDX (TRIG_IDX)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .address         (address),
        .chipselect      (chipselect),
        .write_n         (write_n),
        .writedata       (writedata),
        .byteenable      (byteenable),
        .readdata        (readdata),
        .readdatavalid   (readdatavalid),
        .i_snap_req      (i_snap_req),
        .i_var           (i_var),
        .o_reg           (o_reg),
        .o_wr_stb        (o_wr_stb),
        .o_latch_trigger (o_latch_trigger)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input int unsigned a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        address = AW'(a); chipselect = 1'b1; write_n = 1'b0; writedata = d; byteenable = be;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input int unsigned a, output logic [31:0] d, output logic v);
        @(negedge clk);
        address = AW'(a); chipselect = 1'b1; write_n = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
        d = readdata; v = readdatavalid;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic v;
        repeat (3) @(negedge clk);
        tests++; if (o_reg !== '0) begin fails++; $display("FAIL reset_oreg got %0h want 0", o_reg); end
        tests++; if (o_wr_stb !== '0) begin fails++; $display("FAIL reset_stb got %0h want 0", o_wr_stb); end
        tests++; if (readdata !== '0 || readdatavalid !== 1'b0) begin
            fails++; $display("FAIL reset_rd got %0h/%0b want 0/0", readdata, readdatavalid); end
        tests++; if (o_latch_trigger !== 1'b0) begin fails++; $display("FAIL reset_latch got %0b want 0", o_latch_trigger); end
        rst_n = 1'b1;
        bus_read(CTRL, d, v);
        tests++; if (d !== 32'h0 || v !== 1'b1) begin fails++; $display("FAIL reset_ctrl got %0h/%0b want 0/1", d, v); end
    endtask

    task automatic test_write();
        logic [31:0] d; logic v; logic [N_RW-1:0] exp_stb;
        bus_write(5, 32'h12345678, 4'hF);
        exp_stb = '0; exp_stb[5] = 1'b1;
        tests++; if (o_reg[5*DW +: DW] !== 32'h12345678) begin fails++; $display("FAIL wr5_oreg got %0h want 12345678", o_reg[5*DW +: DW]); end
        tests++; if (o_wr_stb !== exp_stb) begin fails++; $display("FAIL wr5_stb got %0h want %0h", o_wr_stb, exp_stb); end
        @(negedge clk);
        tests++; if (o_wr_stb !== '0) begin fails++; $display("FAIL wr5_stb_len got %0h want 0", o_wr_stb); end
        bus_write(0, 32'hA5A50001, 4'hF);
        tests++; if (o_reg[0 +: DW] !== 32'hA5A50001) begin fails++; $display("FAIL wr0_oreg got %0h want a5a50001", o_reg[0 +: DW]); end
        bus_write(N_RW - 1, 32'h80000000, 4'hF);
        exp_stb = '0; exp_stb[N_RW-1] = 1'b1;
        tests++; if (o_reg[(N_RW-1)*DW +: DW] !== 32'h80000000) begin fails++; $display("FAIL wr59_oreg got %0h want 80000000", o_reg[(N_RW-1)*DW +: DW]); end
        tests++; if (o_wr_stb !== exp_stb) begin fails++; $display("FAIL wr59_stb got %0h want %0h", o_wr_stb, exp_stb); end
        bus_read(5, d, v);
        tests++; if (d !== 32'h12345678 || v !== 1'b1) begin fails++; $display("FAIL rd5 got %0h/%0b want 12345678/1", d, v); end
    endtask

    task automatic test_snapshot();
        logic [31:0] d; logic v;
        i_var[0 +: DW] = 32'hA;
        i_var[TRIG_IDX*DW +: DW] = 32'hB;
        bus_read(N_RW + TRIG_IDX, d, v);
        tests++; if (d !== 32'hB || v !== 1'b1) begin fails++; $display("FAIL trig_rd got %0h/%0b want b/1", d, v); end
        tests++; if (o_latch_trigger !== 1'b0) begin fails++; $display("FAIL latch_early got %0b want 0", o_latch_trigger); end
        @(negedge clk);
        tests++; if (o_latch_trigger !== 1'b1) begin fails++; $display("FAIL latch_pulse got %0b want 1", o_latch_trigger); end
        i_var[0 +: DW] = 32'hC;
        bus_read(N_RW, d, v);
        tests++; if (d !== 32'hA) begin fails++; $display("FAIL shadow0 got %0h want a", d); end
        tests++; if (o_latch_trigger !== 1'b0) begin fails++; $display("FAIL latch_len got %0b want 0", o_latch_trigger); end
        bus_read(CTRL, d, v);
        tests++; if (d !== 32'h00010000) begin fails++; $display("FAIL seq1 got %0h want 10000", d); end
    endtask

    task automatic test_live();
        logic [31:0] d; logic v; logic [31:0] e;
        bus_write(CTRL, 32'h1, 4'hF);
        @(negedge clk);
        address = AW'(N_RW + 3); chipselect = 1'b1; write_n = 1'b1;
        i_var[3*DW +: DW] = 32'h100;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            e = 32'h100 + 32'(k - 1);
            tests++; if (readdata !== e || readdatavalid !== 1'b1) begin
                fails++; $display("FAIL live_%0d got %0h/%0b want %0h/1", k, readdata, readdatavalid, e); end
            i_var[3*DW +: DW] = 32'h100 + 32'(k);
        end
        chipselect = 1'b0;
        bus_write(CTRL, 32'h0, 4'hF);
        bus_read(N_RW + 3, d, v);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL live_off got %0h want 0", d); end
    endtask

    task automatic test_err();
        logic [31:0] d; logic v;
        bus_write(N_RW + 2, 32'hDEAD, 4'hF);
        tests++; if (o_wr_stb !== '0) begin fails++; $display("FAIL ro_wr_stb got %0h want 0", o_wr_stb); end
        tests++; if (o_reg[2*DW +: DW] !== 32'h0) begin fails++; $display("FAIL ro_wr_oreg got %0h want 0", o_reg[2*DW +: DW]); end
        bus_read(CTRL, d, v);
        tests++; if (d !== 32'h00010002) begin fails++; $display("FAIL err_set got %0h want 10002", d); end
        bus_write(CTRL, 32'h2, 4'hF);
        bus_read(CTRL, d, v);
        tests++; if (d !== 32'h00010000) begin fails++; $display("FAIL err_clr got %0h want 10000", d); end
        bus_read(250, d, v);
        tests++; if (d !== 32'h0 || v !== 1'b1) begin fails++; $display("FAIL unmapped_rd got %0h/%0b want 0/1", d, v); end
        bus_write(250, 32'h1, 4'hF);
        bus_read(CTRL, d, v);
        tests++; if (d !== 32'h00010002) begin fails++; $display("FAIL unmapped_wr got %0h want 10002", d); end
        bus_write(CTRL, 32'h2, 4'hF);
        bus_read(CTRL, d, v);
        tests++; if (d !== 32'h00010000) begin fails++; $display("FAIL err_clr2 got %0h want 10000", d); end
    endtask

    task automatic test_chipselect();
        @(negedge clk);
        address = AW'(5); chipselect = 1'b0; write_n = 1'b0; writedata = 32'hFFFFFFFF;
        @(negedge clk);
        write_n = 1'b1;
        tests++; if (o_reg[5*DW +: DW] !== 32'h12345678 || o_wr_stb !== '0) begin
            fails++; $display("FAIL cs_low got %0h/%0h want 12345678/0", o_reg[5*DW +: DW], o_wr_stb); end
        tests++; if (readdatavalid !== 1'b0) begin fails++; $display("FAIL cs_low_rdv got %0b want 0", readdatavalid); end
    endtask

    task automatic test_byteen();
        logic [N_RW-1:0] exp_stb; logic [31:0] e;
        bus_write(9, 32'hFFFFFFFF, 4'hF);
        bus_write(9, 32'h11223344, 4'b0010);
`ifdef GYRO_VAR_BANK_BYTEEN_EN
        e = 32'hFFFF33FF;
`else
        e = 32'h11223344;
`endif
        exp_stb = '0; exp_stb[9] = 1'b1;
        tests++; if (o_reg[9*DW +: DW] !== e) begin fails++; $display("FAIL byteen got %0h want %0h", o_reg[9*DW +: DW], e); end
        tests++; if (o_wr_stb !== exp_stb) begin fails++; $display("FAIL byteen_stb got %0h want %0h", o_wr_stb, exp_stb); end
    endtask

    task automatic test_reset_mid_snapshot();
        logic [31:0] d; logic v; int pulses;
        bus_write(7, 32'h77, 4'hF);
        i_var[0 +: DW] = 32'h55;
        @(negedge clk); i_snap_req = 1'b1;
        @(negedge clk); i_snap_req = 1'b0;
        rst_n = 1'b0;
        #1;
        tests++; if (o_reg !== '0 || o_wr_stb !== '0) begin fails++; $display("FAIL midrst_regs got %0h/%0h want 0/0", o_reg[7*DW +: DW], o_wr_stb); end
        tests++; if (readdata !== '0 || readdatavalid !== 1'b0 || o_latch_trigger !== 1'b0) begin
            fails++; $display("FAIL midrst_out got %0h/%0b/%0b want 0/0/0", readdata, readdatavalid, o_latch_trigger); end
        @(negedge clk); rst_n = 1'b1;
        pulses = 0;
        repeat (4) begin @(negedge clk); if (o_latch_trigger === 1'b1) pulses++; end
        tests++; if (pulses != 0) begin fails++; $display("FAIL midrst_pulse got %0d want 0", pulses); end
        bus_read(CTRL, d, v);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL midrst_ctrl got %0h want 0", d); end
        bus_read(N_RW, d, v);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL midrst_shadow got %0h want 0", d); end
    endtask

    task automatic test_seq_wrap();
        logic [31:0] d; logic v; int pulses;
        @(negedge clk); i_snap_req = 1'b1;
        repeat (65535) @(negedge clk);
        i_snap_req = 1'b0;
        bus_read(CTRL, d, v);
        tests++; if (d !== 32'hFFFF0000) begin fails++; $display("FAIL seq_max got %0h want ffff0000", d); end
        @(negedge clk); i_snap_req = 1'b1;
        @(negedge clk); i_snap_req = 1'b0;
        bus_read(CTRL, d, v);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL seq_wrap got %0h want 0", d); end
        @(negedge clk);
        address = AW'(N_RW + TRIG_IDX); chipselect = 1'b1; write_n = 1'b1; i_snap_req = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; i_snap_req = 1'b0;
        tests++; if (readdata !== 32'hB) begin fails++; $display("FAIL coinc_rd got %0h want b", readdata); end
        pulses = (o_latch_trigger === 1'b1) ? 1 : 0;
        repeat (3) begin @(negedge clk); if (o_latch_trigger === 1'b1) pulses++; end
        tests++; if (pulses != 1) begin fails++; $display("FAIL coinc_pulse got %0d want 1", pulses); end
        bus_read(CTRL, d, v);
        tests++; if (d !== 32'h00010000) begin fails++; $display("FAIL coinc_seq got %0h want 10000", d); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_snapshot();
        test_live();
        test_err();
        test_chipselect();
        test_byteen();
        test_reset_mid_snapshot();
        test_seq_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
